// File: rtl/noc_inject_sched.sv
// Injection sequencer for the NoC adder top: per packet pulses START then START2,
// waits for a rising DONE edge, captures DATA, and repeats for a programmed count.
module noc_inject_sched #(
    parameter int TDATAW      = 512,
    parameter int CNTW        = 16,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              GO,
    input  logic              ABORT,
    input  logic [CNTW-1:0]   NUM_PKT,
    output logic              START_O,
    output logic              START2_O,
    input  logic              DONE_I,
    input  logic [TDATAW-1:0] DATA_I,
    output logic [TDATAW-1:0] RESULT_O,
    output logic              RESULT_VALID_O,
    output logic [CNTW-1:0]   PKT_CNT_O,
    output logic              BUSY_O,
    output logic              FINISHED_O,
    output logic              ERR_TIMEOUT_O
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE1, S_ISSUE2, S_WAIT_DONE, S_GAP, S_FINISH
    } state_t;

    state_t          r_state;
    logic [CNTW-1:0] r_num;
    logic [GW-1:0]   r_gap_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic            r_done_q;

    logic            w_evt;
    logic [CNTW-1:0] w_cnt_inc;

    // Only a fresh rising edge counts, so a DONE left high from the previous packet is ignored.
    assign w_evt     = DONE_I & ~r_done_q &
                       ((r_state == S_ISSUE2) || (r_state == S_WAIT_DONE));
    assign w_cnt_inc = PKT_CNT_O + CNTW'(1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state        <= S_IDLE;
            r_num          <= '0;
            r_gap_cnt      <= '0;
            r_to_cnt       <= '0;
            r_done_q       <= 1'b0;
            START_O        <= 1'b0;
            START2_O       <= 1'b0;
            RESULT_O       <= '0;
            RESULT_VALID_O <= 1'b0;
            PKT_CNT_O      <= '0;
            BUSY_O         <= 1'b0;
            FINISHED_O     <= 1'b0;
            ERR_TIMEOUT_O  <= 1'b0;
        end else begin
            r_done_q       <= DONE_I;
            START_O        <= 1'b0;
            START2_O       <= 1'b0;
            RESULT_VALID_O <= 1'b0;
            FINISHED_O     <= 1'b0;

            // Abort outranks completion and timeout; counters and result are left intact.
            if (ABORT && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                BUSY_O  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (GO && !ABORT) begin
                            r_num         <= NUM_PKT;
                            PKT_CNT_O     <= '0;
                            ERR_TIMEOUT_O <= 1'b0;
                            BUSY_O        <= 1'b1;
                            if (NUM_PKT == '0) begin
                                r_state <= S_FINISH;
                            end else begin
                                r_state <= S_ISSUE1;
                                START_O <= 1'b1;
                            end
                        end
                    end

                    S_ISSUE1: begin
                        r_state  <= S_ISSUE2;
                        START2_O <= 1'b1;
                    end

                    S_ISSUE2, S_WAIT_DONE: begin
                        if (r_state == S_ISSUE2) r_to_cnt <= '0;
                        if (w_evt) begin
                            RESULT_O       <= DATA_I;
                            RESULT_VALID_O <= 1'b1;
                            PKT_CNT_O      <= w_cnt_inc;
                            if (w_cnt_inc == r_num) begin
                                r_state <= S_FINISH;
                            end else if (GAP_CYC == 0) begin
                                r_state <= S_ISSUE1;
                                START_O <= 1'b1;
                            end else begin
                                r_state   <= S_GAP;
                                r_gap_cnt <= '0;
                            end
                        end else if (r_state == S_ISSUE2) begin
                            r_state <= S_WAIT_DONE;
                        end else if (r_to_cnt == TO_LAST) begin
                            ERR_TIMEOUT_O <= 1'b1;
                            r_state       <= S_FINISH;
                        end else begin
                            r_to_cnt <= r_to_cnt + TW'(1);
                        end
                    end

                    S_GAP: begin
                        if (r_gap_cnt == GAP_LAST) begin
                            r_state <= S_ISSUE1;
                            START_O <= 1'b1;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + GW'(1);
                        end
                    end

                    S_FINISH: begin
                        FINISHED_O <= 1'b1;
                        BUSY_O     <= 1'b0;
                        r_state    <= S_IDLE;
                    end

                    default: begin
                        BUSY_O  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
